// File: rtl/axi4_lite_regport_if.sv
// AXI4-Lite channel bundle between a PS-side master and the register-port slave.
// Signal names follow the AXI port naming used by the slave's documentation.
interface axi4_lite_regport_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;

    modport master (
        output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
    );

    modport slave (
        input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
    );
endinterface

// File: rtl/axi4_lite_regport.sv
// AXI4-Lite slave bridging register accesses onto a strobe-based set/get port,
// with independent AW/W acceptance, range decode (DECERR) and read timeout (SLVERR).
module axi4_lite_regport #(
    parameter int unsigned                   C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                   C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = 32'h4000_0000,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_HIGHADDR         = 32'h4001_ffff,
    parameter int unsigned                   C_RD_TIMEOUT       = 16
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    axi4_lite_regport_if.slave                s_axi,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     set_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     set_data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   set_strb,
    output logic                              set_stb,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     get_addr,
    output logic                              get_stb,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     get_data,
    input  logic                              get_ack
);
    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [7:0] RD_LAST     = 8'(C_RD_TIMEOUT - 1);

    typedef enum logic [1:0] {WR_IDLE, WR_WRITE, WR_RESP} wr_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_e;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a >= C_BASEADDR) && (a <= C_HIGHADDR);
    endfunction

    // Write path state
    wr_state_e         wr_state_q, wr_state_d;
    logic              aw_have_q, aw_have_d, w_have_q, w_have_d;
    logic              aw_ok_q, aw_ok_d;
    logic [AW-1:0]     aw_off_q, aw_off_d;
    logic [DW-1:0]     w_data_q, w_data_d;
    logic [SW-1:0]     w_strb_q, w_strb_d;
    logic [AW-1:0]     set_addr_q, set_addr_d;
    logic [DW-1:0]     set_data_q, set_data_d;
    logic [SW-1:0]     set_strb_q, set_strb_d;
    logic              set_stb_q, set_stb_d;
    logic              awready_q, awready_d, wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              aw_hs, w_hs;

    // Read path state
    rd_state_e         rd_state_q, rd_state_d;
    logic [7:0]        rd_cnt_q, rd_cnt_d;
    logic [AW-1:0]     get_addr_q, get_addr_d;
    logic              get_stb_q, get_stb_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              ar_hs;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        wr_state_d = wr_state_q;
        aw_have_d  = aw_have_q;
        w_have_d   = w_have_q;
        aw_ok_d    = aw_ok_q;
        aw_off_d   = aw_off_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        set_addr_d = set_addr_q;
        set_data_d = set_data_q;
        set_strb_d = set_strb_q;
        set_stb_d  = 1'b0;
        awready_d  = 1'b0;
        wready_d   = 1'b0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        aw_hs      = s_axi.S_AXI_AWVALID && awready_q;
        w_hs       = s_axi.S_AXI_WVALID && wready_q;

        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs) begin
                    aw_have_d = 1'b1;
                    aw_ok_d   = in_range(s_axi.S_AXI_AWADDR);
                    aw_off_d  = s_axi.S_AXI_AWADDR - C_BASEADDR;
                end
                if (w_hs) begin
                    w_have_d = 1'b1;
                    w_data_d = s_axi.S_AXI_WDATA;
                    w_strb_d = s_axi.S_AXI_WSTRB;
                end
                // Both halves present: fire the strobe next cycle using this cycle's captures.
                if (aw_have_d && w_have_d) begin
                    wr_state_d = WR_WRITE;
                    set_stb_d  = aw_ok_d;
                    bresp_d    = aw_ok_d ? RESP_OKAY : RESP_DECERR;
                    if (aw_ok_d) begin
                        set_addr_d = aw_off_d;
                        set_data_d = w_data_d;
                        set_strb_d = w_strb_d;
                    end
                end else begin
                    awready_d = !aw_have_d;
                    wready_d  = !w_have_d;
                end
            end
            WR_WRITE: begin
                aw_have_d  = 1'b0;
                w_have_d   = 1'b0;
                bvalid_d   = 1'b1;
                wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        get_addr_d = get_addr_q;
        get_stb_d  = 1'b0;
        arready_d  = 1'b0;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        ar_hs      = s_axi.S_AXI_ARVALID && arready_q;

        case (rd_state_q)
            RD_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d  = 1'b0;
                    get_addr_d = s_axi.S_AXI_ARADDR - C_BASEADDR;
                    if (in_range(s_axi.S_AXI_ARADDR)) begin
                        rd_state_d = RD_WAIT;
                        rd_cnt_d   = 8'd0;
                        get_stb_d  = 1'b1;
                    end else begin
                        rd_state_d = RD_RESP;
                        rdata_d    = '0;
                        rresp_d    = RESP_DECERR;
                        rvalid_d   = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                // An ack arriving on the expiry cycle still wins over the timeout.
                if (get_ack) begin
                    rd_state_d = RD_RESP;
                    rdata_d    = get_data;
                    rresp_d    = RESP_OKAY;
                    rvalid_d   = 1'b1;
                end else if (rd_cnt_q == RD_LAST) begin
                    rd_state_d = RD_RESP;
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    rvalid_d   = 1'b1;
                end else begin
                    rd_cnt_d = rd_cnt_q + 8'd1;
                end
            end
            RD_RESP: begin
                if (s_axi.S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state_q <= WR_IDLE;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            aw_ok_q    <= 1'b0;
            aw_off_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            set_addr_q <= '0;
            set_data_q <= '0;
            set_strb_q <= '0;
            set_stb_q  <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= 8'd0;
            get_addr_q <= '0;
            get_stb_q  <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            wr_state_q <= wr_state_d;
            aw_have_q  <= aw_have_d;
            w_have_q   <= w_have_d;
            aw_ok_q    <= aw_ok_d;
            aw_off_q   <= aw_off_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            set_addr_q <= set_addr_d;
            set_data_q <= set_data_d;
            set_strb_q <= set_strb_d;
            set_stb_q  <= set_stb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            get_addr_q <= get_addr_d;
            get_stb_q  <= get_stb_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign set_addr            = set_addr_q;
    assign set_data            = set_data_q;
    assign set_strb            = set_strb_q;
    assign set_stb             = set_stb_q;
    assign get_addr            = get_addr_q;
    assign get_stb             = get_stb_q;
endmodule

// File: tb/tb_axi4_lite_regport.sv
// Self-checking bench for axi4_lite_regport: directed and randomized AXI traffic
// compared against a timing/response model derived from the slave's documented rules.
module tb_axi4_lite_regport;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] HIGH = 32'h4001_ffff;
    localparam int          TO   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] set_addr, set_data, get_addr, get_data;
    logic [3:0]  set_strb;
    logic        set_stb, get_stb, get_ack;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    axi4_lite_regport_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi4_lite_regport #(
        .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(32),
        .C_BASEADDR(BASE),
        .C_HIGHADDR(HIGH),
        .C_RD_TIMEOUT(TO)
    ) dut (
        .S_AXI_ACLK  (clk),
        .S_AXI_ARESET(rst),
        .s_axi       (bus),
        .set_addr    (set_addr),
        .set_data    (set_data),
        .set_strb    (set_strb),
        .set_stb     (set_stb),
        .get_addr    (get_addr),
        .get_stb     (get_stb),
        .get_data    (get_data),
        .get_ack     (get_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitors, sampled mid-cycle
    typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } set_ev_t;
    typedef struct { int cyc; logic [31:0] addr; } get_ev_t;
    set_ev_t set_q[$];
    get_ev_t get_q[$];
    set_ev_t se;
    get_ev_t ge;

    always @(negedge clk) begin
        if (set_stb === 1'b1) begin
            se.cyc = cyc; se.addr = set_addr; se.data = set_data; se.strb = set_strb;
            set_q.push_back(se);
        end
        if (get_stb === 1'b1) begin
            ge.cyc = cyc; ge.addr = get_addr;
            get_q.push_back(ge);
        end
    end

    // Reference model: decode and expected response timing from the documented rules
    function automatic bit mdl_in_range(input logic [31:0] a);
        return (a >= BASE) && (a <= HIGH);
    endfunction

    function automatic logic [142:0] outs();
        return {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_RVALID,
                bus.S_AXI_BVALID, bus.S_AXI_RRESP, bus.S_AXI_BRESP, bus.S_AXI_RDATA,
                set_stb, get_stb, set_addr, set_data, set_strb, get_addr};
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, input string tag);
        bit aw_done = 0, w_done = 0, b_done = 0, unstable = 0;
        int t = 0, hs_cyc = -1, bv_first = -1, bv_hold = 0, ready_bad = 0, q0, n_ev;
        logic [1:0] resp_seen = 2'b00;
        bit in_rng = mdl_in_range(addr);
        q0 = set_q.size();
        while (!b_done && t < 300) begin
            bus.S_AXI_AWADDR  = addr;
            bus.S_AXI_AWVALID = !aw_done && (t >= aw_dly);
            bus.S_AXI_WDATA   = data;
            bus.S_AXI_WSTRB   = strb;
            bus.S_AXI_WVALID  = !w_done && (t >= w_dly);
            if (bus.S_AXI_BVALID) begin
                if (bv_first < 0) begin bv_first = cyc; resp_seen = bus.S_AXI_BRESP; end
                else if (bus.S_AXI_BRESP !== resp_seen) unstable = 1;
                bus.S_AXI_BREADY = (cyc - bv_first) >= b_dly;
                if (!bus.S_AXI_BREADY) bv_hold++;
            end else begin
                bus.S_AXI_BREADY = 1'b0;
            end
            if ((aw_done && bus.S_AXI_AWREADY) || (w_done && bus.S_AXI_WREADY)) ready_bad++;
            if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) aw_done = 1;
            if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) w_done = 1;
            if (aw_done && w_done && hs_cyc < 0) hs_cyc = cyc;
            if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) b_done = 1;
            @(negedge clk);
            t++;
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;

        total++; if (!b_done) begin bad++; $display("FAIL %s write_timeout: no B handshake within 300 cycles", tag); end
        n_ev = set_q.size() - q0;
        total++; if (n_ev != (in_rng ? 1 : 0)) begin bad++; $display("FAIL %s set_stb_count got=%0d exp=%0d", tag, n_ev, in_rng ? 1 : 0); end
        if (in_rng && n_ev == 1) begin
            total++; if (set_q[q0].cyc != hs_cyc + 1) begin bad++; $display("FAIL %s set_stb_cycle got=%0d exp=%0d", tag, set_q[q0].cyc, hs_cyc + 1); end
            total++; if (set_q[q0].addr !== addr - BASE) begin bad++; $display("FAIL %s set_addr got=%h exp=%h", tag, set_q[q0].addr, addr - BASE); end
            total++; if (set_q[q0].data !== data) begin bad++; $display("FAIL %s set_data got=%h exp=%h", tag, set_q[q0].data, data); end
            total++; if (set_q[q0].strb !== strb) begin bad++; $display("FAIL %s set_strb got=%h exp=%h", tag, set_q[q0].strb, strb); end
        end
        total++; if (bv_first != hs_cyc + 2) begin bad++; $display("FAIL %s bvalid_cycle got=%0d exp=%0d", tag, bv_first, hs_cyc + 2); end
        total++; if (resp_seen !== (in_rng ? 2'b00 : 2'b11)) begin bad++; $display("FAIL %s bresp got=%b exp=%b", tag, resp_seen, in_rng ? 2'b00 : 2'b11); end
        total++; if (unstable || bv_hold != b_dly) begin bad++; $display("FAIL %s bvalid_hold got=%0d unstable=%0d exp=%0d", tag, bv_hold, unstable, b_dly); end
        total++; if (ready_bad != 0) begin bad++; $display("FAIL %s ready_low got=%0d exp=0 cycles with READY after accept", tag, ready_bad); end
    endtask

    // ack_dly: RD_WAIT cycle index (0 = get_stb cycle) in which get_ack rises; negative = never
    task automatic axi_read(input logic [31:0] addr, input int ack_dly, input logic [31:0] val,
                            input int r_dly, input string tag);
        bit ar_done = 0, r_done = 0, unstable = 0;
        int t = 0, hs_cyc = -1, rv_first = -1, rv_hold = 0, q0, n_ev, exp_cyc;
        logic [31:0] d_seen = '0, exp_data;
        logic [1:0]  r_seen = 2'b00, exp_resp;
        bit in_rng = mdl_in_range(addr);
        q0 = get_q.size();
        while (!r_done && t < 300) begin
            bus.S_AXI_ARADDR  = addr;
            bus.S_AXI_ARVALID = !ar_done;
            if (hs_cyc >= 0 && ack_dly >= 0 && cyc == hs_cyc + 1 + ack_dly) begin
                get_ack = 1'b1; get_data = val;
            end else if (rv_first >= 0) begin
                get_ack = 1'b1; get_data = ~val;
            end else begin
                get_ack = 1'b0; get_data = $urandom;
            end
            if (bus.S_AXI_RVALID) begin
                if (rv_first < 0) begin rv_first = cyc; d_seen = bus.S_AXI_RDATA; r_seen = bus.S_AXI_RRESP; end
                else if (bus.S_AXI_RDATA !== d_seen || bus.S_AXI_RRESP !== r_seen) unstable = 1;
                bus.S_AXI_RREADY = (cyc - rv_first) >= r_dly;
                if (!bus.S_AXI_RREADY) rv_hold++;
            end else begin
                bus.S_AXI_RREADY = 1'b0;
            end
            if (bus.S_AXI_ARVALID && bus.S_AXI_ARREADY) begin ar_done = 1; hs_cyc = cyc; end
            if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) r_done = 1;
            @(negedge clk);
            t++;
        end
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;
        get_ack           = 1'b0;

        if (!in_rng) begin
            exp_cyc = hs_cyc + 1; exp_resp = 2'b11; exp_data = 32'h0;
        end else if (ack_dly >= 0 && ack_dly <= TO - 1) begin
            exp_cyc = hs_cyc + 2 + ack_dly; exp_resp = 2'b00; exp_data = val;
        end else begin
            exp_cyc = hs_cyc + 1 + TO; exp_resp = 2'b10; exp_data = 32'h0;
        end
        total++; if (!r_done) begin bad++; $display("FAIL %s read_timeout: no R handshake within 300 cycles", tag); end
        n_ev = get_q.size() - q0;
        total++; if (n_ev != (in_rng ? 1 : 0)) begin bad++; $display("FAIL %s get_stb_count got=%0d exp=%0d", tag, n_ev, in_rng ? 1 : 0); end
        if (in_rng && n_ev == 1) begin
            total++; if (get_q[q0].cyc != hs_cyc + 1) begin bad++; $display("FAIL %s get_stb_cycle got=%0d exp=%0d", tag, get_q[q0].cyc, hs_cyc + 1); end
            total++; if (get_q[q0].addr !== addr - BASE) begin bad++; $display("FAIL %s get_addr got=%h exp=%h", tag, get_q[q0].addr, addr - BASE); end
        end
        total++; if (rv_first != exp_cyc) begin bad++; $display("FAIL %s rvalid_cycle got=%0d exp=%0d", tag, rv_first, exp_cyc); end
        total++; if (d_seen !== exp_data) begin bad++; $display("FAIL %s rdata got=%h exp=%h", tag, d_seen, exp_data); end
        total++; if (r_seen !== exp_resp) begin bad++; $display("FAIL %s rresp got=%b exp=%b", tag, r_seen, exp_resp); end
        total++; if (unstable || rv_hold != r_dly) begin bad++; $display("FAIL %s rvalid_hold got=%0d unstable=%0d exp=%0d", tag, rv_hold, unstable, r_dly); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (outs() !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", outs()); end
        rst = 1'b0;
        total++; if (outs() !== '0) begin bad++; $display("FAIL post_reset_cycle got=%h exp=0", outs()); end
        @(negedge clk);
        total++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b11100) begin
            bad++; $display("FAIL idle_ready got=%b exp=11100", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID});
        end
    endtask

    task automatic test_write_basic();
        axi_write(32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, "wr_same_cycle");
    endtask

    task automatic test_write_split();
        axi_write(32'h4000_0004, 32'h1234_5678, 4'h3, 3, 0, 5, "wr_w_first");
        axi_write(32'h4000_0100, 32'hCAFE_F00D, 4'hC, 0, 4, 2, "wr_aw_first");
    endtask

    task automatic test_read_ack();
        axi_read(32'h4000_0008, 0, 32'hA5A5_A5A5, 3, "rd_ack_first");
        axi_read(32'h4000_0030, 5, 32'h0BAD_CAFE, 1, "rd_ack_late");
    endtask

    task automatic test_read_timeout();
        axi_read(32'h4000_0020, -1, 32'h1111_1111, 0, "rd_timeout");
    endtask

    task automatic test_decode();
        axi_write(32'h5000_0000, 32'h7777_7777, 4'hF, 0, 0, 1, "wr_decerr");
        axi_read(32'h3FFF_FFFC, 0, 32'h8888_8888, 1, "rd_decerr");
    endtask

    task automatic test_boundaries();
        axi_write(BASE, 32'h0000_0001, 4'h1, 0, 0, 0, "wr_base");
        axi_write(32'h4001_FFFC, 32'h0000_0002, 4'h8, 1, 1, 0, "wr_top");
        axi_write(HIGH + 32'd1, 32'h0000_0003, 4'hF, 0, 0, 0, "wr_above_top");
        axi_read(32'h4001_FFFC, TO - 1, 32'h5A5A_5A5A, 0, "rd_ack_at_expiry");
        axi_read(BASE, TO, 32'h6B6B_6B6B, 0, "rd_ack_after_expiry");
    endtask

    task automatic test_reset_mid();
        int t = 0, s0, g0;
        bit seen_b = 0, seen_r = 0;
        bus.S_AXI_AWADDR = BASE + 32'h40; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h1357_9BDF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = BASE + 32'h44; bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0; get_ack = 1'b0;
        while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY && bus.S_AXI_ARREADY) && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        t = 0;
        while (!bus.S_AXI_BVALID && t < 20) begin @(negedge clk); t++; end
        total++; if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 2'b10) begin bad++; $display("FAIL rst_mid_setup got=%b exp=10", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (outs() !== '0) begin bad++; $display("FAIL rst_mid_outputs got=%h exp=0", outs()); end
        rst = 1'b0;
        s0 = set_q.size(); g0 = get_q.size();
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.S_AXI_BVALID) seen_b = 1;
            if (bus.S_AXI_RVALID) seen_r = 1;
        end
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        total++; if (seen_b || seen_r) begin bad++; $display("FAIL rst_mid_no_resp got b=%0d r=%0d exp b=0 r=0", seen_b, seen_r); end
        total++; if (set_q.size() != s0 || get_q.size() != g0) begin bad++; $display("FAIL rst_mid_no_stb got set=%0d get=%0d exp 0 0", set_q.size() - s0, get_q.size() - g0); end
        axi_write(BASE + 32'h48, 32'h2468_ACE0, 4'h5, 0, 0, 0, "wr_after_rst");
        axi_read(BASE + 32'h4C, 2, 32'hFEDC_BA98, 0, "rd_after_rst");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            axi_write(BASE + 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF, 0, 0, 0, "wr_b2b");
        for (int i = 0; i < 4; i++)
            axi_read(BASE + 32'(i * 4), 0, 32'h2000_0000 + 32'(i), 0, "rd_b2b");
    endtask

    task automatic test_random_concurrent();
        for (int i = 0; i < 12; i++) begin
            logic [31:0] wa, ra, wd, rv;
            logic [3:0]  ws;
            int awd, wwd, bd, ad, rd;
            wa  = ($urandom_range(0, 3) != 0) ? BASE + (32'($urandom) & 32'h0001_FFFC) : 32'($urandom);
            ra  = ($urandom_range(0, 3) != 0) ? BASE + (32'($urandom) & 32'h0001_FFFC) : 32'($urandom);
            wd  = $urandom;
            rv  = $urandom;
            ws  = 4'($urandom);
            awd = int'($urandom_range(0, 4));
            wwd = int'($urandom_range(0, 4));
            bd  = int'($urandom_range(0, 3));
            ad  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 20));
            rd  = int'($urandom_range(0, 3));
            fork
                axi_write(wa, wd, ws, awd, wwd, bd, "wr_rand");
                axi_read(ra, ad, rv, rd, "rd_rand");
            join
        end
    endtask

    initial begin
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0;
        bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
        get_ack = 1'b0; get_data = '0;
        test_reset();
        test_write_basic();
        test_write_split();
        test_read_ack();
        test_read_timeout();
        test_decode();
        test_boundaries();
        test_reset_mid();
        test_back_to_back();
        test_random_concurrent();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi4_lite_regport.md
Name: axi4_lite_regport

Overview:
Parametrised AXI4-Lite slave that bridges PS-side register accesses onto a simple strobe-based register port for accelerator logic. It succeeds the single-cycle get/set slave with these additions:
- AW and W channels accepted independently and in either order.
- Byte-strobe forwarding on writes.
- Held write responses.
- Address-range decode with DECERR.
- Handshaked reads via get_ack, with a timeout that returns SLVERR.

Parameters:
C_BASEADDR, 32'h40000000, lowest decoded byte address.
C_HIGHADDR, 32'h4001ffff, highest decoded byte address (inclusive).
C_S_AXI_ADDR_WIDTH, 32, AXI address width; also width of set_addr/get_addr.
C_S_AXI_DATA_WIDTH, 32, AXI data width (32 or 64).
C_RD_TIMEOUT, 16, cycles to wait for get_ack before answering SLVERR (range 1..255).

Ports:
S_AXI_ACLK  in  1  clock; everything is synchronous to its rising edge.
S_AXI_ARESET  in  1  synchronous, active-high reset.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
S_AXI_RRESP  out  2  read response: 00 OKAY, 10 SLVERR, 11 DECERR.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  write byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
set_addr  out  C_S_AXI_ADDR_WIDTH  write offset (AWADDR minus C_BASEADDR).
set_data  out  C_S_AXI_DATA_WIDTH  write data.
set_strb  out  C_S_AXI_DATA_WIDTH/8  write byte strobes.
set_stb  out  1  one-cycle write strobe.
get_addr  out  C_S_AXI_ADDR_WIDTH  read offset.
get_stb  out  1  one-cycle read request.
get_data  in  C_S_AXI_DATA_WIDTH  read data from user logic.
get_ack  in  1  get_data valid.

Behaviour:
Reset:
- All outputs are 0 during reset and in the first cycle after it, including every READY, RVALID, BVALID, both strobes, and all address/data/strb registers.
- Both FSMs go to IDLE.
- Reset mid-transaction abandons the transaction; no strobe or response is issued for it.

Address decode:
- An address is in range when C_BASEADDR <= addr <= C_HIGHADDR (unsigned compare).
- Offset = addr - C_BASEADDR, truncated to C_S_AXI_ADDR_WIDTH.

Write FSM, states WR_IDLE, WR_WRITE, WR_RESP:
- WR_IDLE:
  - AWREADY = !aw_have; WREADY = !w_have.
  - An AW handshake latches the offset, the range flag and sets aw_have.
  - A W handshake latches WDATA and WSTRB and sets w_have.
  - AW and W handshakes in the same cycle are both accepted.
  - Once aw_have and w_have are both set, go to WR_WRITE.
- WR_WRITE (1 cycle):
  - In range: set_stb=1, BRESP=OKAY.
  - Out of range: set_stb stays 0, BRESP=DECERR.
  - Clear aw_have and w_have; go to WR_RESP.
- WR_RESP:
  - BVALID=1, with BRESP held stable until BREADY.
  - On the handshake, go to WR_IDLE.
- AWREADY and WREADY are 0 in WR_WRITE and WR_RESP.
- Minimum latency: AW+W in cycle N gives set_stb in N+1 and BVALID in N+2.
- set_addr, set_data and set_strb hold their values until the next write.

Read FSM, states RD_IDLE, RD_WAIT, RD_RESP:
- RD_IDLE:
  - ARREADY=1.
  - On handshake, latch get_addr.
  - In range: go to RD_WAIT, clear the timeout counter, and pulse get_stb=1 for exactly the first RD_WAIT cycle.
  - Out of range: go to RD_RESP with RDATA=0 and RRESP=DECERR; get_stb is never pulsed.
- RD_WAIT:
  - get_ack is sampled every cycle, including the get_stb cycle.
  - On get_ack: latch get_data into RDATA, RRESP=OKAY, go to RD_RESP.
  - Otherwise increment the counter.
  - When the counter reaches C_RD_TIMEOUT-1 without get_ack: RDATA=0, RRESP=SLVERR, go to RD_RESP.
  - get_ack on the same cycle the counter expires takes priority (OKAY).
- RD_RESP:
  - RVALID=1, with RDATA and RRESP stable until RREADY.
  - On the handshake, go to RD_IDLE.
- get_ack outside RD_WAIT is ignored.
- Read and write FSMs are fully independent; concurrent read and write are allowed.

Test Plan:
- Write 0x40000010 data 0xDEADBEEF WSTRB 0xF, AW and W in the same cycle -> set_stb pulses one cycle later with set_addr=0x10, set_data=0xDEADBEEF, set_strb=0xF; BVALID follows with BRESP=00.
- W (0x12345678, WSTRB 0x3) 3 cycles before AW 0x40000004, BREADY held low 5 cycles -> exactly one set_stb with offset 0x4, strb 0x3; BVALID held 5 cycles; AWREADY and WREADY stay 0 until the B handshake.
- Read 0x40000008 with get_ack asserted in the get_stb cycle, get_data=0xA5A5A5A5 -> RVALID two cycles after the AR handshake, RDATA=0xA5A5A5A5, RRESP=00; RREADY low 3 cycles keeps RDATA stable.
- Read 0x40000020 with get_ack never asserted, C_RD_TIMEOUT=16 -> RVALID in the 16th RD_WAIT cycle plus one, RDATA=0, RRESP=10.
- Write 0x50000000 and read 0x3FFFFFFC -> no set_stb and no get_stb; BRESP=11, RRESP=11, RDATA=0.
- Assert S_AXI_ARESET during WR_RESP and during RD_WAIT -> BVALID and RVALID drop to 0; no response is issued afterwards, and the next write/read completes normally.
